// File: rtl/db_pkg.sv
// Shared definitions for the key/value database request path: op encodings,
// target flow states, default widths and the request-generator FSM states.
package db_pkg;

    localparam int unsigned DEF_KEY_SIZE  = 96;
    localparam int unsigned DEF_VAL_SIZE  = 32;
    localparam int unsigned DEF_HASH_SIZE = 32;
    localparam int unsigned OP_W          = 4;
    localparam int unsigned FLAG_W        = 4;
    localparam int unsigned SLICE_W       = 32;

    localparam logic SET_REQ = 1'b1;
    localparam logic GET_REQ = 1'b0;

    typedef enum logic [1:0] {
        TGT_IDLE    = 2'd0,
        TGT_SUSPECT = 2'd1,
        TGT_ARREST  = 2'd2,
        TGT_EXPIRE  = 2'd3
    } tgt_state_e;

    // Op field as carried on pkt_op / db_in_op
    typedef struct packed {
        logic       rsvd;
        tgt_state_e tgt;
        logic       set;
    } db_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HASH  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } fsm_state_e;

endpackage

// File: rtl/db_key_hash.sv
// Folds a flow key into a hash by XOR-ing all of its 32-bit slices.
module db_key_hash
    import db_pkg::*;
#(
    parameter int unsigned KEY_SIZE  = DEF_KEY_SIZE,
    parameter int unsigned HASH_SIZE = DEF_HASH_SIZE
) (
    input  logic [KEY_SIZE-1:0]  key_i,
    output logic [HASH_SIZE-1:0] hash_o
);

    localparam int unsigned SLICES = KEY_SIZE / SLICE_W;

    logic [SLICE_W-1:0] fold_c;

    always_comb begin
        fold_c = '0;
        for (int unsigned i = 0; i < SLICES; i++) begin
            fold_c = fold_c ^ key_i[i*SLICE_W +: SLICE_W];
        end
    end

    assign hash_o = HASH_SIZE'(fold_c);

endmodule

// File: rtl/db_req_gen.sv
// Request initiator for db_cont: accepts a lookup/update, issues a one-cycle
// request with a folded hash, collects the flag response in a fixed window.
module db_req_gen
    import db_pkg::*;
#(
    parameter int unsigned HASH_SIZE   = DEF_HASH_SIZE,
    parameter int unsigned KEY_SIZE    = DEF_KEY_SIZE,
    parameter int unsigned VAL_SIZE    = DEF_VAL_SIZE,
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    output logic                 pkt_ready,
    input  logic [OP_W-1:0]      pkt_op,
    input  logic [KEY_SIZE-1:0]  pkt_key,
    input  logic [VAL_SIZE-1:0]  pkt_value,
    output logic                 db_in_valid,
    output logic [OP_W-1:0]      db_in_op,
    output logic [HASH_SIZE-1:0] db_in_hash,
    output logic [KEY_SIZE-1:0]  db_in_key,
    output logic [VAL_SIZE-1:0]  db_in_value,
    input  logic                 db_out_valid,
    input  logic [FLAG_W-1:0]    db_out_flag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_hit,
    output logic [FLAG_W-1:0]    rsp_flag,
    output logic [OP_W-1:0]      rsp_op,
    output logic [CNT_WIDTH-1:0] req_cnt,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] stray_cnt
);

    localparam int unsigned WCNT_W = 4;

    fsm_state_e           state_q, state_d;
    logic                 pkt_ready_q, pkt_ready_d;
    db_op_t               op_q, op_d;
    logic [KEY_SIZE-1:0]  key_q, key_d;
    logic [VAL_SIZE-1:0]  value_q, value_d;
    logic [HASH_SIZE-1:0] hash_q, hash_d;
    logic                 db_in_valid_q, db_in_valid_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic                 hit_q, hit_d;
    logic [FLAG_W-1:0]    flag_q, flag_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [CNT_WIDTH-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] stray_cnt_q, stray_cnt_d;
    logic [HASH_SIZE-1:0] hash_c;

    db_key_hash #(
        .KEY_SIZE  (KEY_SIZE),
        .HASH_SIZE (HASH_SIZE)
    ) u_key_hash (
        .key_i  (key_q),
        .hash_o (hash_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        pkt_ready_d   = pkt_ready_q;
        op_d          = op_q;
        key_d         = key_q;
        value_d       = value_q;
        hash_d        = hash_q;
        db_in_valid_d = 1'b0;
        wcnt_d        = wcnt_q;
        hit_d         = hit_q;
        flag_d        = flag_q;
        rsp_valid_d   = rsp_valid_q;
        req_cnt_d     = req_cnt_q;
        hit_cnt_d     = hit_cnt_q;
        stray_cnt_d   = stray_cnt_q;

        // Responses outside the WAIT window are only counted
        if (db_out_valid && (state_q != ST_WAIT) && !(&stray_cnt_q)) begin
            stray_cnt_d = stray_cnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (pkt_valid && pkt_ready_q) begin
                    op_d        = db_op_t'(pkt_op);
                    key_d       = pkt_key;
                    value_d     = pkt_value;
                    pkt_ready_d = 1'b0;
                    state_d     = ST_HASH;
                end
            end
            ST_HASH: begin
                hash_d        = hash_c;
                db_in_valid_d = 1'b1;
                state_d       = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!(&req_cnt_q)) begin
                    req_cnt_d = req_cnt_q + CNT_WIDTH'(1);
                end
                wcnt_d  = WCNT_W'(WAIT_CYCLES);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q - WCNT_W'(1);
                if (db_out_valid && !hit_q) begin
                    hit_d  = 1'b1;
                    flag_d = db_out_flag;
                end
                if (wcnt_q == WCNT_W'(1)) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (hit_q && !(&hit_cnt_q)) begin
                        hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
                    end
                    hit_d       = 1'b0;
                    flag_d      = '0;
                    rsp_valid_d = 1'b0;
                    pkt_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                pkt_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pkt_ready_q   <= 1'b1;
            op_q          <= '0;
            key_q         <= '0;
            value_q       <= '0;
            hash_q        <= '0;
            db_in_valid_q <= 1'b0;
            wcnt_q        <= '0;
            hit_q         <= 1'b0;
            flag_q        <= '0;
            rsp_valid_q   <= 1'b0;
            req_cnt_q     <= '0;
            hit_cnt_q     <= '0;
            stray_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pkt_ready_q   <= pkt_ready_d;
            op_q          <= op_d;
            key_q         <= key_d;
            value_q       <= value_d;
            hash_q        <= hash_d;
            db_in_valid_q <= db_in_valid_d;
            wcnt_q        <= wcnt_d;
            hit_q         <= hit_d;
            flag_q        <= flag_d;
            rsp_valid_q   <= rsp_valid_d;
            req_cnt_q     <= req_cnt_d;
            hit_cnt_q     <= hit_cnt_d;
            stray_cnt_q   <= stray_cnt_d;
        end
    end

    assign pkt_ready   = pkt_ready_q;
    assign db_in_valid = db_in_valid_q;
    assign db_in_op    = op_q;
    assign db_in_hash  = hash_q;
    assign db_in_key   = key_q;
    assign db_in_value = value_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_hit     = hit_q;
    assign rsp_flag    = flag_q;
    assign rsp_op      = op_q;
    assign req_cnt     = req_cnt_q;
    assign hit_cnt     = hit_cnt_q;
    assign stray_cnt   = stray_cnt_q;

endmodule

// File: doc/db_req_gen.md
# db_req_gen

Request initiator for the key/value database controller (`db_cont`). It accepts one lookup or update per handshake from the packet-parsing front end and folds the 96-bit flow key into a 32-bit hash. It then issues a single-cycle request pulse on the controller's request port, holding all request fields stable while the controller walks its check/miss/update states. Finally it captures any flag response within a fixed window and returns a completed result upstream with a valid/ready handshake.

## Interface
- `HASH_SIZE`, 32, hash width driven to the controller
- `KEY_SIZE`, 96, flow key width; multiple of 32
- `VAL_SIZE`, 32, value width
- `WAIT_CYCLES`, 4, response window after the issue cycle; legal range 3..15
- `CNT_WIDTH`, 32, statistics counter width
- `clk` in 1 — system clock; the only clock
- `rst` in 1 — reset, synchronous, active-high
- `pkt_valid` in 1 — upstream request valid
- `pkt_ready` out 1 — request accepted when `pkt_valid & pkt_ready`
- `pkt_op` in 4 — bit0: 1 = SET, 0 = GET; bits 2:1: target state (IDLE/SUSPECT/ARREST/EXPIRE = 0/1/2/3)
- `pkt_key` in KEY_SIZE — flow key
- `pkt_value` in VAL_SIZE — value for SET
- `db_in_valid` out 1 — request pulse to the controller
- `db_in_op` out 4 — registered op
- `db_in_hash` out HASH_SIZE — registered folded hash
- `db_in_key` out KEY_SIZE — registered key
- `db_in_value` out VAL_SIZE — registered value
- `db_out_valid` in 1 — controller response strobe
- `db_out_flag` in 4 — controller response flag
- `rsp_valid` out 1 — result valid
- `rsp_ready` in 1 — upstream accepts result
- `rsp_hit` out 1 — a controller response was seen inside the window
- `rsp_flag` out 4 — captured flag; 0 when `rsp_hit` = 0
- `rsp_op` out 4 — echo of the request op
- `req_cnt` out CNT_WIDTH — requests issued; saturating
- `hit_cnt` out CNT_WIDTH — results with `rsp_hit` = 1; saturating
- `stray_cnt` out CNT_WIDTH — `db_out_valid` pulses seen outside a window; saturating

## Operation
- Reset values:
  - all outputs 0, except `pkt_ready` = 1
  - state = IDLE; counters cleared
- FSM:
  - IDLE: `pkt_ready` = 1. On handshake, register op, key and value, then go to HASH.
  - HASH: register the hash in `db_in_hash`, then go to ISSUE.
  - ISSUE: `db_in_valid` = 1 for exactly this cycle; `req_cnt`++. Load the wait counter with WAIT_CYCLES, then go to WAIT.
  - WAIT: decrement the counter each cycle. On the first `db_out_valid`, set the hit flag and latch `db_out_flag`; later pulses in the same window are ignored and not counted. When the counter reaches 0, go to RESP.
  - RESP: `rsp_valid` = 1, with `rsp_*` stable until `rsp_ready`. On handshake, `hit_cnt`++ if hit, clear hit and flag, then go to IDLE.
- Hash: XOR of all 32-bit slices of the key (bits 31:0 ^ 63:32 ^ 95:64). It is not masked; the controller applies its own index mask.
- `db_in_op`, `db_in_key`, `db_in_value` and `db_in_hash` hold from HASH until the next accepted request; they are never changed during WAIT.
- `db_in_valid` is never high for more than one consecutive cycle.
- `stray_cnt` increments on `db_out_valid` in IDLE, HASH, ISSUE or RESP.
- Counter rule: each counter holds at all-ones.
- Reset during any state aborts the transaction immediately. No `rsp_valid` is produced for it; `db_in_valid` is low in the cycle after reset is asserted.

## Timing
- Handshake at cycle T:
  - HASH at T+1; `db_in_valid` at T+2
  - window T+3 .. T+2+WAIT_CYCLES
  - `rsp_valid` first high at T+3+WAIT_CYCLES
- With `rsp_ready` held high, `pkt_ready` returns at T+4+WAIT_CYCLES: one request per WAIT_CYCLES+4 cycles (8 at default).
- A `db_out_valid` pulse in the same cycle as `db_in_valid` is outside the window and counts as stray.
- A pulse in the last WAIT cycle is captured.
- `rsp_ready` low stalls RESP indefinitely; `pkt_ready` stays 0.

## Structure
- Shared package `db_pkg`, holding:
  - `SET_REQ`/`GET_REQ` op bit values
  - state encodings IDLE/SUSPECT/ARREST/EXPIRE
  - default key, value and hash widths
  - FSM state constants
- Sub-module `db_key_hash`: combinational XOR fold, parameterised by KEY_SIZE and HASH_SIZE, registered by the parent in HASH.

## Test plan
- GET of key 96'h0000_0001_0000_0002_0000_0004, with no controller response:
  - `db_in_hash` = 32'h7 and a single `db_in_valid` pulse at T+2
  - `rsp_valid` at T+7 with `rsp_hit` = 0 and `rsp_flag` = 0
- SET with op 4'b0011, where the controller model returns flag 4'hA at T+5:
  - `rsp_hit` = 1, `rsp_flag` = 4'hA, `rsp_op` = 4'h3
  - `hit_cnt` = 1
- Back-to-back with `pkt_valid` and `rsp_ready` held high:
  - handshakes every 8 cycles; `req_cnt` = 5 after 5 requests
  - `db_in_key` stable throughout each WAIT
- Window edges:
  - response at T+2 → `stray_cnt` = 1 and `rsp_hit` = 0
  - response at T+6 → `rsp_hit` = 1
  - two responses in one window → first flag kept
- `rsp_ready` low for 10 cycles: `rsp_*` held, `pkt_ready` = 0, no second `db_in_valid`.
- `rst` asserted during WAIT:
  - next cycle all outputs at reset values and `pkt_ready` = 1
  - no `rsp_valid` ever for the aborted request
